// File: rtl/elevator_pkg.sv
// Shared elevator definitions: stepper FSM states, phase-to-drive encoding
// and acceleration-ramp multipliers.
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SETTLE = 2'd2
  } step_state_e;

  // Drive encoding is {x, y}; the complements go to xb/yb.
  localparam logic [1:0] PH0_DRV = 2'b00;
  localparam logic [1:0] PH1_DRV = 2'b10;
  localparam logic [1:0] PH2_DRV = 2'b11;
  localparam logic [1:0] PH3_DRV = 2'b01;

  localparam int RAMP_MUL_SLOW   = 4;
  localparam int RAMP_MUL_MID    = 2;
  localparam int RAMP_MUL_FAST   = 1;
  localparam int RAMP_MUL_MAX    = RAMP_MUL_SLOW;
  localparam int RAMP_SLOW_STEPS = 2;
  localparam int RAMP_MID_STEPS  = 4;

  function automatic logic [1:0] phase_drive(input logic [1:0] phase);
    logic [1:0] drv;
    case (phase)
      2'd0:    drv = PH0_DRV;
      2'd1:    drv = PH1_DRV;
      2'd2:    drv = PH2_DRV;
      2'd3:    drv = PH3_DRV;
      default: drv = PH0_DRV;
    endcase
    return drv;
  endfunction

  function automatic logic [2:0] ramp_mul(input logic [2:0] step_idx);
    logic [2:0] mul;
    if (step_idx < 3'(RAMP_SLOW_STEPS)) begin
      mul = 3'(RAMP_MUL_SLOW);
    end else if (step_idx < 3'(RAMP_MID_STEPS)) begin
      mul = 3'(RAMP_MUL_MID);
    end else begin
      mul = 3'(RAMP_MUL_FAST);
    end
    return mul;
  endfunction

endpackage

// File: rtl/stepper_ctrl_step_timer.sv
// Loadable down-counter that emits a one-cycle tick every period_i enabled
// cycles; clr_i restarts the count so the first tick lands period_i cycles later.
module step_timer #(
  parameter int TW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [TW-1:0] period_i,
  output logic          tick_o
);

  logic [TW-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == {TW{1'b0}});

  // Reload on clear or on tick, otherwise count down while enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {TW{1'b0}};
    end else if (clr_i || tick_o) begin
      cnt_q <= period_i - TW'(1);
    end else if (en_i) begin
      cnt_q <= cnt_q - TW'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

endmodule

// File: rtl/stepper_ctrl.sv
// Counted, abortable 4-phase stepper move sequencer with position tracking.
// Optional macro STEPPER_RAMP_EN adds an acceleration ramp at the start of each move.
module stepper_ctrl
  import elevator_pkg::*;
#(
  parameter int STEP_DIV   = 50000,
  parameter int SETTLE_CYC = 25000,
  parameter int CNT_W      = 16,
  parameter int POS_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_dir_i,
  input  logic [CNT_W-1:0] cmd_steps_i,
  input  logic             abort_i,
  output logic             x_o,
  output logic             y_o,
  output logic             xb_o,
  output logic             yb_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic [POS_W-1:0] position_o
);

  localparam int TW = $clog2(RAMP_MUL_MAX * STEP_DIV + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);

  step_state_e      state_q;
  logic [1:0]       phase_q;
  logic [1:0]       phase_d;
  logic [1:0]       drive_d;
  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_d;
  logic [CNT_W-1:0] remaining_q;
  logic             dir_q;
  logic [SW-1:0]    settle_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;
  logic             x_q;
  logic             y_q;
  logic             xb_q;
  logic             yb_q;

  logic             accept_s;
  logic             tick_s;
  logic             step_s;
  logic [TW-1:0]    period_s;

  assign accept_s = cmd_valid_i && (state_q == ST_IDLE);
  // An abort in the same cycle as a tick suppresses that step.
  assign step_s   = (state_q == ST_RUN) && tick_s && !abort_i;

  // Phase and position one step on in the latched direction.
  always_comb begin
    phase_d = phase_q;
    pos_d   = pos_q;
    if (dir_q) begin
      phase_d = phase_q + 2'd1;
      pos_d   = pos_q + POS_W'(1);
    end else begin
      phase_d = phase_q - 2'd1;
      pos_d   = pos_q - POS_W'(1);
    end
  end

  assign drive_d = phase_drive(phase_d);

`ifdef STEPPER_RAMP_EN
  logic [2:0] ramp_k_q;
  logic [2:0] ramp_k_d;

  // Index of the step whose period is being loaded; saturates once at full speed.
  always_comb begin
    if (accept_s) begin
      ramp_k_d = 3'd0;
    end else if (ramp_k_q < 3'(RAMP_MID_STEPS)) begin
      ramp_k_d = ramp_k_q + 3'd1;
    end else begin
      ramp_k_d = ramp_k_q;
    end
  end

  // Ramp step index register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ramp_k_q <= 3'd0;
    end else if (accept_s || step_s) begin
      ramp_k_q <= ramp_k_d;
    end else begin
      ramp_k_q <= ramp_k_q;
    end
  end

  assign period_s = TW'(STEP_DIV * int'(ramp_mul(ramp_k_d)));
`else
  assign period_s = TW'(STEP_DIV);
`endif

  step_timer #(
    .TW(TW)
  ) u_step_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (accept_s),
    .en_i    (state_q == ST_RUN),
    .period_i(period_s),
    .tick_o  (tick_s)
  );

  // Move FSM with registered drive, position and status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      phase_q     <= 2'd0;
      pos_q       <= {POS_W{1'b0}};
      remaining_q <= {CNT_W{1'b0}};
      dir_q       <= 1'b0;
      settle_q    <= {SW{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      x_q         <= 1'b0;
      y_q         <= 1'b0;
      xb_q        <= 1'b1;
      yb_q        <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            aborted_q   <= 1'b0;
            dir_q       <= cmd_dir_i;
            remaining_q <= cmd_steps_i;
            if (cmd_steps_i != {CNT_W{1'b0}}) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort_i) begin
            state_q   <= ST_SETTLE;
            aborted_q <= 1'b1;
            settle_q  <= SW'(SETTLE_CYC - 1);
          end else if (step_s) begin
            phase_q     <= phase_d;
            pos_q       <= pos_d;
            x_q         <= drive_d[1];
            y_q         <= drive_d[0];
            xb_q        <= ~drive_d[1];
            yb_q        <= ~drive_d[0];
            remaining_q <= remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              state_q  <= ST_SETTLE;
              settle_q <= SW'(SETTLE_CYC - 1);
            end
          end
        end
        ST_SETTLE: begin
          if (settle_q == {SW{1'b0}}) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            settle_q <= settle_q - SW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign x_o         = x_q;
  assign y_o         = y_q;
  assign xb_o        = xb_q;
  assign yb_o        = yb_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;
  assign position_o  = pos_q;

endmodule

// File: tb/tb_stepper_ctrl.sv
// Self-checking bench for stepper_ctrl: timeline model plus directed literal checks.
module tb_stepper_ctrl;

  localparam int STEP_DIV   = 4;
  localparam int SETTLE_CYC = 3;
  localparam int CNT_W      = 16;
  localparam int POS_W      = 16;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             cmd_valid_i = 1'b0;
  logic             cmd_ready_o;
  logic             cmd_dir_i = 1'b0;
  logic [CNT_W-1:0] cmd_steps_i = '0;
  logic             abort_i = 1'b0;
  logic             x_o, y_o, xb_o, yb_o;
  logic             busy_o, done_o, aborted_o;
  logic [POS_W-1:0] position_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  stepper_ctrl #(
    .STEP_DIV  (STEP_DIV),
    .SETTLE_CYC(SETTLE_CYC),
    .CNT_W     (CNT_W),
    .POS_W     (POS_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_dir_i  (cmd_dir_i),
    .cmd_steps_i(cmd_steps_i),
    .abort_i    (abort_i),
    .x_o        (x_o),
    .y_o        (y_o),
    .xb_o       (xb_o),
    .yb_o       (yb_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .aborted_o  (aborted_o),
    .position_o (position_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at edge %0d", name, act, exp, cyc);
    end
  endtask

  // Move timeline model: absolute step and done edges derived from the step-period rule.
  function automatic int period(input int k);
`ifdef STEPPER_RAMP_EN
    if (k < 2) return 4 * STEP_DIV;
    else if (k < 4) return 2 * STEP_DIV;
    else return STEP_DIV;
`else
    return STEP_DIV;
`endif
  endfunction

  bit          m_valid = 1'b0;
  int          m_mode = 0;   // 0 idle, 1 moving, 2 settling
  int          m_phase = 0;
  logic [15:0] m_pos = 16'd0;
  bit          m_done = 1'b0;
  bit          m_abt = 1'b0;
  bit          m_dir = 1'b0;
  int          m_left = 0;
  int          m_k = 0;
  int          m_next = 0;
  int          m_end = 0;
  int          x_tab [4] = '{0, 1, 1, 0};
  int          y_tab [4] = '{0, 0, 1, 1};

  always @(posedge clk) begin
    cyc++;
    if (rst_i) begin
      m_valid = 1'b1;
      m_mode  = 0;
      m_phase = 0;
      m_pos   = 16'd0;
      m_done  = 1'b0;
      m_abt   = 1'b0;
    end else if (m_valid) begin
      m_done = 1'b0;
      case (m_mode)
        0: if (cmd_valid_i) begin
          m_abt = 1'b0;
          if (cmd_steps_i == 16'd0) begin
            m_done = 1'b1;
          end else begin
            m_mode = 1;
            m_dir  = cmd_dir_i;
            m_left = int'(cmd_steps_i);
            m_k    = 0;
            m_next = cyc + period(0);
          end
        end
        1: if (abort_i) begin
          m_mode = 2;
          m_abt  = 1'b1;
          m_end  = cyc + SETTLE_CYC;
        end else if (cyc == m_next) begin
          m_phase = m_dir ? (m_phase + 1) % 4 : (m_phase + 3) % 4;
          m_pos   = m_dir ? m_pos + 16'd1 : m_pos - 16'd1;
          m_left--;
          m_k++;
          if (m_left == 0) begin
            m_mode = 2;
            m_end  = cyc + SETTLE_CYC;
          end else begin
            m_next = cyc + period(m_k);
          end
        end
        2: if (cyc == m_end) begin
          m_mode = 0;
          m_done = 1'b1;
        end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("x", 32'(x_o), 32'(x_tab[m_phase]));
      chk("y", 32'(y_o), 32'(y_tab[m_phase]));
      chk("xb", 32'(xb_o), 32'(1 - x_tab[m_phase]));
      chk("yb", 32'(yb_o), 32'(1 - y_tab[m_phase]));
      chk("position", 32'(position_o), 32'(m_pos));
      chk("busy", 32'(busy_o), 32'(m_mode != 0));
      chk("cmd_ready", 32'(cmd_ready_o), 32'(m_mode == 0));
      chk("done", 32'(done_o), 32'(m_done));
      if (m_done) chk("aborted", 32'(aborted_o), 32'(m_abt));
    end
  end

  task automatic at_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic send(input logic dir, input int steps, output int acc);
    cmd_valid_i = 1'b1;
    cmd_dir_i   = dir;
    cmd_steps_i = 16'(steps);
    acc = cyc + 1;
    at_edge(acc);
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    int a;
    int b;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;

    a = cyc;
    at_edge(a + 10);
    chk("rst_pos", 32'(position_o), 32'h0);
    chk("rst_drive", 32'({x_o, y_o, xb_o, yb_o}), 32'h3);
    chk("rst_ready", 32'(cmd_ready_o), 32'h1);

`ifdef STEPPER_RAMP_EN
    send(1'b1, 6, a);
    at_edge(a + 15); chk("ramp_15", 32'(position_o), 32'd0);
    at_edge(a + 16); chk("ramp_16", 32'(position_o), 32'd1);
    at_edge(a + 31); chk("ramp_31", 32'(position_o), 32'd1);
    at_edge(a + 32); chk("ramp_32", 32'(position_o), 32'd2);
    at_edge(a + 40); chk("ramp_40", 32'(position_o), 32'd3);
    at_edge(a + 48); chk("ramp_48", 32'(position_o), 32'd4);
    at_edge(a + 52); chk("ramp_52", 32'(position_o), 32'd5);
    at_edge(a + 55); chk("ramp_55", 32'(position_o), 32'd5);
    at_edge(a + 56); chk("ramp_56", 32'(position_o), 32'd6);
    at_edge(a + 59); chk("ramp_done", 32'(done_o), 32'h1);
    // A second move restarts the slow ramp.
    send(1'b0, 1, a);
    at_edge(a + 15); chk("ramp2_15", 32'(position_o), 32'd6);
    at_edge(a + 16); chk("ramp2_16", 32'(position_o), 32'd5);
    at_edge(a + 20);
`else
    send(1'b1, 5, a);
    chk("fwd_busy", 32'(busy_o), 32'h1);
    chk("fwd_ready", 32'(cmd_ready_o), 32'h0);
    at_edge(a + 3);  chk("fwd_xy3", 32'({x_o, y_o}), 32'h0);
    at_edge(a + 4);  chk("fwd_xy4", 32'({x_o, y_o}), 32'h2);
    at_edge(a + 8);  chk("fwd_xy8", 32'({x_o, y_o}), 32'h3);
    at_edge(a + 20); chk("fwd_pos", 32'(position_o), 32'd5);
    chk("fwd_xy20", 32'({x_o, y_o}), 32'h2);
    at_edge(a + 22); chk("fwd_nodone", 32'(done_o), 32'h0);
    at_edge(a + 23); chk("fwd_done", 32'(done_o), 32'h1);
    chk("fwd_abt", 32'(aborted_o), 32'h0);
    chk("fwd_idle", 32'({busy_o, cmd_ready_o}), 32'h1);
    at_edge(a + 24); chk("fwd_pulse", 32'(done_o), 32'h0);

    // Reset in the middle of a move.
    send(1'b1, 5, a);
    at_edge(a + 6); chk("mid_pos", 32'(position_o), 32'd6);
    rst_i = 1'b1;
    at_edge(a + 7);
    chk("mid_rst_pos", 32'(position_o), 32'd0);
    chk("mid_rst_st", 32'({busy_o, cmd_ready_o, done_o}), 32'h2);
    rst_i = 1'b0;
    at_edge(a + 12);

    send(1'b0, 3, a);
    at_edge(a + 4);  chk("rev_xy4", 32'({x_o, y_o}), 32'h1);
    at_edge(a + 8);  chk("rev_xy8", 32'({x_o, y_o}), 32'h3);
    at_edge(a + 12); chk("rev_xy12", 32'({x_o, y_o}), 32'h2);
    chk("rev_pos", 32'(position_o), 32'hFFFD);
    at_edge(a + 15); chk("rev_done", 32'(done_o), 32'h1);
    send(1'b1, 3, b);
    chk("b2b_acc", 32'(b), 32'(a + 16));
    at_edge(b + 12); chk("b2b_pos", 32'(position_o), 32'd0);
    chk("b2b_xy", 32'({x_o, y_o}), 32'h0);
    at_edge(b + 15); chk("b2b_done", 32'(done_o), 32'h1);

    send(1'b1, 10, a);
    at_edge(a + 11); abort_i = 1'b1;
    at_edge(a + 12); abort_i = 1'b0;
    chk("abt_pos", 32'(position_o), 32'd2);
    chk("abt_xy", 32'({x_o, y_o}), 32'h3);
    at_edge(a + 14); chk("abt_nodone", 32'(done_o), 32'h0);
    at_edge(a + 15); chk("abt_done", 32'(done_o), 32'h1);
    chk("abt_flag", 32'(aborted_o), 32'h1);

    // Abort while idle has no effect.
    abort_i = 1'b1;
    at_edge(a + 18); abort_i = 1'b0;
    chk("idle_abt", 32'({cmd_ready_o, busy_o}), 32'h2);

    send(1'b0, 0, a);
    chk("zero_done", 32'(done_o), 32'h1);
    chk("zero_abt", 32'(aborted_o), 32'h0);
    chk("zero_busy", 32'(busy_o), 32'h0);
    chk("zero_pos", 32'(position_o), 32'd2);
    at_edge(a + 1); chk("zero_pulse", 32'(done_o), 32'h0);

    // A request presented while busy is not latched.
    send(1'b1, 2, a);
    cmd_valid_i = 1'b1;
    cmd_dir_i   = 1'b0;
    cmd_steps_i = 16'd7;
    for (int i = 1; i <= 6; i++) begin
      at_edge(a + i);
      chk("busy_ready", 32'(cmd_ready_o), 32'h0);
    end
    cmd_valid_i = 1'b0;
    at_edge(a + 11); chk("ign_done", 32'(done_o), 32'h1);
    chk("ign_pos", 32'(position_o), 32'd4);
    at_edge(a + 20); chk("ign_idle_pos", 32'(position_o), 32'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
